// File: rtl/scratch_mem_arbiter_if.sv
// Shared scratch-memory port bundle: requester side, memory side and status flags.
interface scratch_mem_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ*ADDR_W-1:0] req_read_addr;
  logic [NREQ*ADDR_W-1:0] req_write_addr;
  logic [NREQ-1:0]        req_write_en;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        grant;
  logic                   grant_valid;
  logic [2:0]             grant_id;
  logic [ADDR_W-1:0]      scratch_mem_read_addr;
  logic [ADDR_W-1:0]      scratch_mem_write_addr;
  logic                   scratch_mem_write_en;
  logic [DATA_W-1:0]      scratch_mem_out;
  logic [DATA_W-1:0]      scratch_mem_in;
  logic [DATA_W-1:0]      rd_data;
  logic                   hold_timeout;
  logic                   conflict;

  modport slave (
    input  req, lock, req_read_addr, req_write_addr, req_write_en, req_data, scratch_mem_in,
    output grant, grant_valid, grant_id, scratch_mem_read_addr, scratch_mem_write_addr,
           scratch_mem_write_en, scratch_mem_out, rd_data, hold_timeout, conflict
  );

  modport master (
    output req, lock, req_read_addr, req_write_addr, req_write_en, req_data, scratch_mem_in,
    input  grant, grant_valid, grant_id, scratch_mem_read_addr, scratch_mem_write_addr,
           scratch_mem_write_en, scratch_mem_out, rd_data, hold_timeout, conflict
  );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// Round-robin arbiter for the single scratch-memory port, with hold limit and
// sticky protocol flags.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   S_IDLE    | no grant; arbitrate every edge
//   S_GRANTED | one grant bit set; re-arbitrate on release
module scratch_mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input logic                clock,
  input logic                reset,
  scratch_mem_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_GRANTED = 1'b1;

  logic [0:0]      state;
  logic [NREQ-1:0] grant_q;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic            hold_timeout_q;
  logic            conflict_q;

  logic [2:0]      holder_id;
  logic            holder_req;
  logic            holder_lock;
  logic            release_now;
  logic            forced_release;
  logic [NREQ-1:0] others;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] win_onehot;
  logic            win_found;
  logic [PTR_W-1:0] ptr_next;

  // Decode the current holder and decide whether it lets go at this edge.
  always_comb begin
    holder_id   = '0;
    holder_req  = 1'b0;
    holder_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        holder_id   = 3'(i);
        holder_req  = bus.req[i];
        holder_lock = bus.lock[i];
      end
    end
    forced_release = (state == S_GRANTED) && holder_req && holder_lock && (hold_cnt == HOLD_LAST);
    release_now    = (state == S_GRANTED) &&
                     (!holder_req || !holder_lock || (hold_cnt == HOLD_LAST));
  end

  // Round-robin search from ptr; the holder is skipped only if someone else is waiting.
  always_comb begin
    int idx;
    idx        = 0;
    others     = bus.req & ~grant_q;
    cand       = ((state == S_GRANTED) && (others != '0)) ? others : bus.req;
    win_found  = 1'b0;
    win_onehot = '0;
    ptr_next   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!win_found && cand[idx]) begin
        win_found       = 1'b1;
        win_onehot[idx] = 1'b1;
        ptr_next        = PTR_W'((idx + 1) % NREQ);
      end
    end
  end

  // Grant register, pointer, hold counter and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      grant_q        <= '0;
      ptr            <= '0;
      hold_cnt       <= '0;
      hold_timeout_q <= 1'b0;
      conflict_q     <= 1'b0;
    end else begin
      if ((state == S_IDLE) || release_now) begin
        hold_cnt <= '0;
        if (win_found) begin
          state   <= S_GRANTED;
          grant_q <= win_onehot;
          ptr     <= ptr_next;
        end else begin
          state   <= S_IDLE;
          grant_q <= '0;
        end
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
      if (forced_release) begin
        hold_timeout_q <= 1'b1;
      end
      if ((bus.req_write_en & ~grant_q) != '0) begin
        conflict_q <= 1'b1;
      end
    end
  end

  // Memory-side mux driven only by the registered grant; zero when idle.
  always_comb begin
    bus.scratch_mem_read_addr  = '0;
    bus.scratch_mem_write_addr = '0;
    bus.scratch_mem_write_en   = 1'b0;
    bus.scratch_mem_out        = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        bus.scratch_mem_read_addr  = bus.req_read_addr[i*ADDR_W +: ADDR_W];
        bus.scratch_mem_write_addr = bus.req_write_addr[i*ADDR_W +: ADDR_W];
        bus.scratch_mem_write_en   = bus.req_write_en[i];
        bus.scratch_mem_out        = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.grant_valid  = |grant_q;
  assign bus.grant_id     = holder_id;
  assign bus.rd_data      = bus.scratch_mem_in;
  assign bus.hold_timeout = hold_timeout_q;
  assign bus.conflict     = conflict_q;
endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Directed bench for scratch_mem_arbiter (NREQ=4, MAX_HOLD=8).
module tb_scratch_mem_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  scratch_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  scratch_mem_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clr;
    bus.req            = '0;
    bus.lock           = '0;
    bus.req_write_en   = '0;
    bus.req_read_addr  = '0;
    bus.req_write_addr = '0;
    bus.req_data       = '0;
  endtask

  task automatic set_slot(input int k, input logic [ADDR_W-1:0] ra,
                          input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d);
    bus.req_read_addr[k*ADDR_W +: ADDR_W]  = ra;
    bus.req_write_addr[k*ADDR_W +: ADDR_W] = wa;
    bus.req_data[k*DATA_W +: DATA_W]       = d;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    clr();
    step();
    step();
    reset = 1'b1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    reset = 1'b1;
    clr();
    bus.scratch_mem_in = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_valid", bus.grant_valid, 0);
    chk("rst_id", bus.grant_id, 0);
    chk("rst_raddr", bus.scratch_mem_read_addr, 0);
    chk("rst_waddr", bus.scratch_mem_write_addr, 0);
    chk("rst_we", bus.scratch_mem_write_en, 0);
    chk("rst_out", bus.scratch_mem_out, 0);
    chk("rst_timeout", bus.hold_timeout, 0);
    chk("rst_conflict", bus.conflict, 0);
    bus.scratch_mem_in = 32'hCAFE_F00D;
    #1 chk("rd_data", bus.rd_data, 32'hCAFE_F00D);
    step();
    step();
    reset = 1'b1;

    // single request from requester 1
    set_slot(1, 12'h055, 12'h0A3, 32'h1234);
    bus.req = 4'b0010;
    #1 chk("single_latency", bus.grant, 0);
    step();
    chk("single_grant", bus.grant, 4'b0010);
    chk("single_id", bus.grant_id, 1);
    chk("single_valid", bus.grant_valid, 1);
    chk("single_raddr", bus.scratch_mem_read_addr, 12'h055);
    bus.req = '0;
    bus.req_write_en = 4'b0010;
    #1;
    chk("single_we", bus.scratch_mem_write_en, 1);
    chk("single_waddr", bus.scratch_mem_write_addr, 12'h0A3);
    chk("single_data", bus.scratch_mem_out, 32'h1234);
    step();
    bus.req_write_en = '0;
    #1;
    chk("single_drop", bus.grant, 0);
    chk("single_drop_valid", bus.grant_valid, 0);
    chk("single_drop_we", bus.scratch_mem_write_en, 0);
    chk("single_drop_waddr", bus.scratch_mem_write_addr, 0);
    chk("single_no_conflict", bus.conflict, 0);
    bus.req = 4'b1111;
    step();
    chk("ptr_after_single", bus.grant, 4'b0100);
    bus.req = '0;
    step();

    // round robin, all requesting
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_%0d", k), bus.grant, rr_exp[k]);
    end
    bus.req = '0;
    step();

    // locked hold of requester 0 while requester 2 waits
    do_reset();
    set_slot(0, 12'h1A5, 12'h000, 32'h0);
    set_slot(2, 12'h2B6, 12'h000, 32'h0);
    bus.req  = 4'b0101;
    bus.lock = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("lock_grant_%0d", j), bus.grant, 4'b0001);
      chk($sformatf("lock_raddr_%0d", j), bus.scratch_mem_read_addr, 12'h1A5);
      if (j == 4) bus.lock = 4'b0000;
    end
    step();
    chk("lock_next_grant", bus.grant, 4'b0100);
    chk("lock_next_id", bus.grant_id, 2);
    chk("lock_next_raddr", bus.scratch_mem_read_addr, 12'h2B6);
    chk("lock_no_timeout", bus.hold_timeout, 0);
    clr();
    step();

    // hold timeout: requester 1 locked forever, requester 3 waiting
    do_reset();
    bus.req  = 4'b1010;
    bus.lock = 4'b0010;
    for (int j = 0; j < 8; j++) begin
      step();
      chk($sformatf("to_grant_%0d", j), bus.grant, 4'b0010);
      chk($sformatf("to_flag_%0d", j), bus.hold_timeout, 0);
    end
    step();
    chk("to_moved", bus.grant, 4'b1000);
    chk("to_set", bus.hold_timeout, 1);
    bus.req = 4'b0010;
    step();
    chk("to_back", bus.grant, 4'b0010);
    chk("to_sticky", bus.hold_timeout, 1);
    clr();
    step();
    chk("to_sticky_idle", bus.hold_timeout, 1);
    chk("to_idle", bus.grant, 0);

    // conflict: requester 2 writes while requester 0 owns the port
    do_reset();
    chk("cf_rst_timeout", bus.hold_timeout, 0);
    chk("cf_rst_conflict", bus.conflict, 0);
    bus.req  = 4'b0001;
    bus.lock = 4'b0001;
    step();
    chk("cf_grant", bus.grant, 4'b0001);
    set_slot(0, 12'h000, 12'h010, 32'hAAAA);
    set_slot(2, 12'h000, 12'h020, 32'hBBBB);
    bus.req_write_en = 4'b0101;
    #1;
    chk("cf_we", bus.scratch_mem_write_en, 1);
    chk("cf_waddr", bus.scratch_mem_write_addr, 12'h010);
    chk("cf_data", bus.scratch_mem_out, 32'hAAAA);
    step();
    chk("cf_set", bus.conflict, 1);
    chk("cf_still_grant", bus.grant, 4'b0001);
    bus.req_write_en = 4'b0100;
    #1;
    chk("cf_we_dropped", bus.scratch_mem_write_en, 0);
    chk("cf_waddr_hold", bus.scratch_mem_write_addr, 12'h010);
    step();
    chk("cf_sticky", bus.conflict, 1);
    clr();
    step();
    step();
    chk("cf_sticky_idle", bus.conflict, 1);
    chk("cf_idle", bus.grant, 0);

    // asynchronous reset during a locked grant
    do_reset();
    bus.req  = 4'b0001;
    bus.lock = 4'b0001;
    step();
    chk("mr_grant", bus.grant, 4'b0001);
    set_slot(0, 12'h111, 12'h3C3, 32'h5555);
    bus.req_write_en = 4'b0001;
    #1;
    chk("mr_we_before", bus.scratch_mem_write_en, 1);
    chk("mr_data_before", bus.scratch_mem_out, 32'h5555);
    #2 reset = 1'b0;
    #1;
    chk("mr_grant_drop", bus.grant, 0);
    chk("mr_id_drop", bus.grant_id, 0);
    chk("mr_we_drop", bus.scratch_mem_write_en, 0);
    chk("mr_waddr_drop", bus.scratch_mem_write_addr, 0);
    chk("mr_raddr_drop", bus.scratch_mem_read_addr, 0);
    chk("mr_data_drop", bus.scratch_mem_out, 0);
    clr();
    bus.req = 4'b1001;
    #1 reset = 1'b1;
    step();
    chk("mr_ptr_restart", bus.grant, 4'b0001);
    chk("mr_ptr_id", bus.grant_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
